// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for the 3x3 streaming convolution top.
// Latches the kernel on start, reads a WIDTH*HEIGHT raster frame from a
// pixel memory (1-cycle read latency), streams it at 1 px/clk, waits a
// drain window for the conv pipeline, then pulses done.
// Optional feature macro: CONV_FRAME_CTRL_PERF_EN (adds cyc_count).
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 single-cycle frame start request
//   busy, done            frame in progress / one-cycle completion pulse
//   cfg_we/addr/wdata     kernel shadow coefficient write (index 0..8)
//   mem_rd_en/addr/rd_data pixel memory read port
//   pix_valid, pix_data   pixel stream to the convolution top
//   k_active              active kernel, k00 in [7:0] .. k22 in [71:64]
//   conv_out_valid        conv top output strobe, counted while busy
//   out_count             valid outputs counted in current/last frame
//   cyc_count             busy cycle count (only with CONV_FRAME_CTRL_PERF_EN)
module conv_frame_ctrl #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256,
    parameter int unsigned BITW   = 8,
    parameter int unsigned AW     = 16,
    parameter int unsigned DRAIN  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [BITW-1:0] mem_rd_data,
    output logic            pix_valid,
    output logic [BITW-1:0] pix_data,
    output logic [71:0]     k_active,
    input  logic            conv_out_valid,
    output logic [AW-1:0]   out_count
`ifdef CONV_FRAME_CTRL_PERF_EN
    ,
    output logic [31:0]     cyc_count
`endif
);

    localparam int unsigned NPIX      = WIDTH * HEIGHT;
    localparam int unsigned LAST_ADDR = NPIX - 1;
    localparam int unsigned KN        = 9;
    // Drain state spans memory latency, the DRAIN window and the cycle
    // that registers the done pulse.
    localparam int unsigned DRAIN_END = DRAIN + 1;
    localparam int unsigned DCW       = $clog2(DRAIN + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Sobel X, row-major, k00 in the low byte.
    localparam logic [KN-1:0][7:0] SOBEL_X = 72'h01_00_FF_02_00_FE_01_00_FF;

    logic [1:0]            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DCW-1:0]        drain_q, drain_d;
    logic                  pix_valid_q;
    logic [BITW-1:0]       pix_hold_q;
    logic [KN-1:0][7:0]    shadow_q, shadow_d;
    logic [KN-1:0][7:0]    active_q, active_d;
    logic [AW-1:0]         out_cnt_q, out_cnt_d;
    logic                  start_acc;
`ifdef CONV_FRAME_CTRL_PERF_EN
    logic [31:0]           cyc_q, cyc_d;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = rd_en_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        out_cnt_d = out_cnt_q;
        start_acc = (state_q == S_IDLE) && start;

        // Shadow write; the copy below uses shadow_q so a coincident
        // write lands only in the next frame's kernel.
        if (cfg_we) begin
            for (int unsigned i = 0; i < KN; i++) begin
                if (cfg_addr == 4'(i)) shadow_d[i] = cfg_wdata;
            end
        end

        if (busy_q && conv_out_valid && (out_cnt_q != '1)) begin
            out_cnt_d = out_cnt_q + AW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    active_d  = shadow_q;
                    addr_d    = '0;
                    rd_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    out_cnt_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (addr_q == AW'(LAST_ADDR)) begin
                    rd_en_d = 1'b0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DCW'(DRAIN_END)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef CONV_FRAME_CTRL_PERF_EN
        cyc_d = cyc_q;
        if (start_acc)   cyc_d = '0;
        else if (busy_q) cyc_d = cyc_q + 32'd1;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            drain_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_hold_q  <= '0;
            shadow_q    <= SOBEL_X;
            active_q    <= SOBEL_X;
            out_cnt_q   <= '0;
`ifdef CONV_FRAME_CTRL_PERF_EN
            cyc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            pix_valid_q <= rd_en_q;
            pix_hold_q  <= pix_data;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            out_cnt_q   <= out_cnt_d;
`ifdef CONV_FRAME_CTRL_PERF_EN
            cyc_q       <= cyc_d;
`endif
        end
    end

    // Memory data arrives in the same cycle pix_valid is high, so it is
    // passed straight through then; otherwise the last pixel is held.
    assign pix_data  = pix_valid_q ? mem_rd_data : pix_hold_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign pix_valid = pix_valid_q;
    assign k_active  = active_q;
    assign out_count = out_cnt_q;
`ifdef CONV_FRAME_CTRL_PERF_EN
    assign cyc_count = cyc_q;
`endif

endmodule
